// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector run controller: latches a pattern configuration on start,
// consumes a fixed window of stream bits over valid/ready and returns the match count.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic [CNT_W-1:0]               cfg_window,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  input  logic                           data_valid,
  input  logic                           data_in,
  output logic                           data_ready,
  output logic                           match_pulse,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [CNT_W-1:0]               res_count,
  output logic                           res_err,
  output logic                           res_aborted
);

  // state  | meaning
  // S_IDLE | waiting for start, configuration not yet latched
  // S_RUN  | accepting stream bits and counting matches
  // S_DONE | result presented until res_ready
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat_q, hist_q, hist_nxt, len_mask;
  logic [LEN_W-1:0]   len_q, fill_q, fill_inc;
  logic               ovl_q;
  logic [CNT_W-1:0]   win_q, bits_q, count_q;
  logic               accept, hit, last_bit, cfg_bad;

  assign cfg_bad  = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN)) || (cfg_window == '0);
  assign accept   = (state == S_RUN) && data_valid;
  assign hist_nxt = {hist_q[MAX_LEN-2:0], data_in};
  assign fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + LEN_W'(1);
  assign last_bit = accept && ((bits_q + CNT_W'(1)) == win_q);
  assign hit      = accept && (fill_inc >= len_q) && (((hist_nxt ^ pat_q) & len_mask) == '0);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (LEN_W'(i) < len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = cfg_bad ? S_DONE : S_RUN;
      S_RUN:  if (abort || last_bit) state_nxt = S_DONE;
      S_DONE: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    data_ready = (state == S_RUN);
    res_valid  = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      win_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bits_q      <= '0;
      count_q     <= '0;
      match_pulse <= 1'b0;
      res_err     <= 1'b0;
      res_aborted <= 1'b0;
    end else begin
      match_pulse <= hit;
      unique case (state)
        S_IDLE: if (start) begin
          pat_q       <= cfg_pattern;
          len_q       <= cfg_len;
          ovl_q       <= cfg_overlap;
          win_q       <= cfg_window;
          hist_q      <= '0;
          fill_q      <= '0;
          bits_q      <= '0;
          count_q     <= '0;
          res_err     <= cfg_bad;
          res_aborted <= 1'b0;
        end
        S_RUN: begin
          if (accept) begin
            hist_q <= hist_nxt;
            bits_q <= bits_q + CNT_W'(1);
            // non-overlapping mode restarts the fill so the next match needs len fresh bits
            fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
            if (hit) count_q <= count_q + CNT_W'(1);
          end
          if (abort) res_aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: expected results are queued at start and checked by a
// monitor whenever a result is presented.
module tb_seq_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_window = '0;
  logic               start = 1'b0, abort = 1'b0, data_valid = 1'b0, data_in = 1'b0, res_ready = 1'b0;
  logic               busy, data_ready, match_pulse, res_valid, res_err, res_aborted;
  logic [CNT_W-1:0]   res_count;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_window(cfg_window), .start(start), .abort(abort),
    .busy(busy), .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .match_pulse(match_pulse), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_err(res_err), .res_aborted(res_aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int err;
    int aborted;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulse_cnt = 0;
  bit   stream [0:255];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: a match ends at bit i when the last len bits equal the pattern (pattern bit 0 is the
  // newest bit); in non-overlapping mode a match may not reuse bits of the previous counted match.
  function automatic int model(input bit [7:0] pat, input int len, input bit ovl, input int n);
    int cnt = 0;
    int last_end = -1000;
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (i >= len - 1) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) if (stream[i-j] != pat[j]) ok = 1'b0;
        if (ok && (ovl || (i - last_end >= len))) begin
          cnt++;
          last_end = i;
        end
      end
    end
    return cnt;
  endfunction

  always @(negedge clk) begin
    if (rst) pulse_cnt = 0;
    else begin
      if (match_pulse) pulse_cnt++;
      if (res_valid) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          check("res_count", int'(res_count), exp_q[0].count);
          check("res_err", int'(res_err), exp_q[0].err);
          check("res_aborted", int'(res_aborted), exp_q[0].aborted);
          check("done_data_ready", int'(data_ready), 0);
          if (res_ready) begin
            check("match_pulses", pulse_cnt, exp_q[0].count);
            void'(exp_q.pop_front());
            pulse_cnt = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    repeat ($urandom_range(0, 2)) begin
      data_in = 1'($urandom);
      tick();
    end
    data_valid = 1'b1;
    data_in    = b;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", int'(busy), 0);
    check("rst_data_ready", int'(data_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_match_pulse", int'(match_pulse), 0);
    check("rst_res_count", int'(res_count), 0);
    check("rst_res_err", int'(res_err), 0);
    check("rst_res_aborted", int'(res_aborted), 0);
  endtask

  task automatic run(input bit [7:0] pat, input int len, input bit ovl, input int win,
                     input int abort_at, input bit mid_start, input int hold);
    exp_t e;
    int   n;
    int   cyc;
    bit   cfg_bad;
    cfg_bad   = (len == 0) || (len > MAX_LEN) || (win == 0);
    n         = cfg_bad ? 0 : ((abort_at >= 0) ? abort_at : win);
    e.count   = cfg_bad ? 0 : model(pat, len, ovl, n);
    e.err     = cfg_bad ? 1 : 0;
    e.aborted = (!cfg_bad && abort_at >= 0) ? 1 : 0;
    exp_q.push_back(e);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cfg_window  = CNT_W'(win);
    start       = 1'b1;
    tick();
    start       = 1'b0;
    cfg_pattern = MAX_LEN'($urandom);
    cfg_len     = LEN_W'($urandom);
    cfg_overlap = 1'($urandom);
    cfg_window  = CNT_W'($urandom);
    if (cfg_bad) begin
      check("err_res_valid_latency", int'(res_valid), 1);
      check("err_no_data_ready", int'(data_ready), 0);
    end else begin
      check("start_data_ready_latency", int'(data_ready), 1);
      for (int i = 0; i < n; i++) begin
        if (mid_start && i == 1) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        send_bit(stream[i]);
      end
      if (abort_at >= 0) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else check("last_bit_res_valid_latency", int'(res_valid), 1);
    end
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!res_valid) begin
      check("res_valid_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    repeat (hold) begin
      abort = 1'($urandom);
      tick();
    end
    abort     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("idle_after_result", int'(busy), 0);
  endtask

  initial begin
    int len, win, ab;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_idle_ignored", int'(busy), 0);

    {stream[0], stream[1], stream[2], stream[3], stream[4]} = 5'b10101;
    run(8'b101, 3, 1'b1, 5, -1, 1'b0, 0);
    run(8'b101, 3, 1'b0, 5, -1, 1'b0, 1);
    run(8'b101, 0, 1'b1, 5, -1, 1'b0, 0);
    run(8'b101, 3, 1'b1, 0, -1, 1'b0, 2);
    run(8'b101, 9, 1'b0, 5, -1, 1'b0, 0);
    {stream[0], stream[1], stream[2], stream[3]} = 4'b1111;
    run(8'b1, 1, 1'b1, 4, -1, 1'b0, 5);
    {stream[0], stream[1], stream[2], stream[3]} = 4'b1011;
    run(8'b101, 3, 1'b1, 10, 4, 1'b0, 2);

    cfg_pattern = 8'b11;
    cfg_len     = LEN_W'(2);
    cfg_overlap = 1'b1;
    cfg_window  = CNT_W'(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs();
    for (int i = 0; i < 8; i++) stream[i] = 1'($urandom);
    run(8'($urandom), 2, 1'b1, 8, -1, 1'b1, 1);

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 64; i++) stream[i] = 1'($urandom);
      case ($urandom_range(0, 19))
        0:       len = 0;
        1:       len = int'($urandom_range(9, 15));
        2, 3, 4: len = int'($urandom_range(5, 8));
        default: len = int'($urandom_range(1, 4));
      endcase
      win = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 30));
      ab  = (win > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, win - 1)) : -1;
      run(8'($urandom), len, 1'($urandom), win, ab, 1'b0, int'($urandom_range(0, 4)));
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
